// File: rtl/approx_add_pipe.sv
// approx_add_pipe: 2-stage valid/ready pipelined adder with selectable lower-part-OR approximation.
// Optional macro ADD_ERR_STAT_EN adds a per-result error flag and a saturating mismatch counter.
module approx_add_pipe #(
    parameter int W           = 16,
    parameter int APPROX_BITS = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic                 cin,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         sum,
    output logic                 cout,
    output logic                 err_flag,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int K  = APPROX_BITS;
    localparam int KL = (K > 0) ? K : 1;
    localparam int HL = (K < W) ? W - K : 1;

    logic          s1_valid, s2_load, accept;
    logic [KL-1:0] low_d, s1_low;
    logic          cmid_d, s1_cmid;
    logic [HL-1:0] ahi_d, bhi_d, s1_ahi, s1_bhi;
    logic [W-1:0]  sum_d;
    logic          cout_d;

    assign s2_load  = s1_valid & (!out_valid | out_ready);
    assign in_ready = !s1_valid | s2_load;
    assign accept   = in_valid & in_ready;

    generate
        if (K > 0) begin : g_lo
            logic [K:0] ex_lo;
            assign ex_lo  = {1'b0, a[K-1:0]} + {1'b0, b[K-1:0]} + (K+1)'(cin);
            assign low_d  = approx_en ? (a[K-1:0] | b[K-1:0] | K'(cin)) : ex_lo[K-1:0];
            assign cmid_d = approx_en ? (a[K-1] & b[K-1]) : ex_lo[K];
        end else begin : g_lo
            assign low_d  = '0;
            assign cmid_d = cin;
        end
        if (K < W) begin : g_hi
            logic [HL:0] hi;
            assign ahi_d  = a[W-1:K];
            assign bhi_d  = b[W-1:K];
            assign hi     = {1'b0, s1_ahi} + {1'b0, s1_bhi} + (HL+1)'(s1_cmid);
            assign cout_d = hi[HL];
            if (K > 0) begin : g_cat
                assign sum_d = {hi[HL-1:0], s1_low};
            end else begin : g_cat
                assign sum_d = hi[HL-1:0];
            end
        end else begin : g_hi
            assign ahi_d  = '0;
            assign bhi_d  = '0;
            assign sum_d  = s1_low;
            assign cout_d = s1_cmid;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_low    <= '0;
            s1_cmid   <= 1'b0;
            s1_ahi    <= '0;
            s1_bhi    <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_low   <= low_d;
                s1_cmid  <= cmid_d;
                s1_ahi   <= ahi_d;
                s1_bhi   <= bhi_d;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                out_valid <= 1'b1;
                sum       <= sum_d;
                cout      <= cout_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ADD_ERR_STAT_EN
    logic [W:0] ex_d, s1_exact;
    assign ex_d = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

    // clear wins over a simultaneous counted consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_exact <= '0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (accept) s1_exact <= ex_d;
            if (s2_load) err_flag <= ({cout_d, sum_d} != s1_exact);
            if (err_clr) err_cnt <= '0;
            else if (out_valid && out_ready && err_flag && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    logic unused_clr;
    assign unused_clr = err_clr;
    assign err_flag   = 1'b0;
    assign err_cnt    = '0;
`endif
endmodule
